// File: rtl/uart_pkg.sv
// Shared UART types and constants.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } uart_rx_state_t;

    localparam logic        START_BIT   = 1'b0;
    localparam logic        STOP_BIT    = 1'b1;
    localparam int unsigned UART_DATA_W = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input. Resets to 1, which is the idle line level.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_W bits LSB first, even parity, stop; 16x oversampled.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_W     = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_clk,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef UART_RX_MAJORITY_EN
    // Deciding one tick after the centre shifts the bit origin by one tick, so later
    // decisions still land at centre+1 when counted from the shifted origin.
    localparam logic [TICK_W-1:0] START_DEC = TICK_W'(OVERSAMPLE / 2);
`else
    localparam logic [TICK_W-1:0] START_DEC = TICK_W'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [TICK_W-1:0] BIT_DEC = TICK_LAST;

    uart_rx_state_t    state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    logic rx_s;
    logic sample;
    logic dec_start;
    logic dec_bit;
    logic stop_done;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Holds rx_s from the two ticks preceding the current one.
    logic [1:0] maj_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maj_q <= 2'b11;
        end else if (baud_clk) begin
            maj_q <= {maj_q[0], rx_s};
        end
    end

    assign sample = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    assign dec_start = baud_clk && (tick_q == START_DEC);
    assign dec_bit   = baud_clk && (tick_q == BIT_DEC);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE: begin
                if (baud_clk && armed_q && (rx_s == START_BIT)) state_d = RX_START;
            end
            RX_START: begin
                if (dec_start) state_d = (sample == START_BIT) ? RX_DATA : RX_IDLE;
            end
            RX_DATA: begin
                if (dec_bit && (bit_q == BIT_LAST)) state_d = RX_PARITY;
            end
            RX_PARITY: begin
                if (dec_bit) state_d = RX_STOP;
            end
            RX_STOP: begin
                if (dec_bit) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != RX_IDLE);
        stop_done = (state_q == RX_STOP) && dec_bit;
    end

    // Datapath next-state
    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        armed_d = armed_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        if (baud_clk) begin
            unique case (state_q)
                RX_IDLE: begin
                    tick_d = '0;
                    if (!armed_q && (rx_s == STOP_BIT)) armed_d = 1'b1;
                end
                RX_START: begin
                    tick_d = dec_start ? '0 : tick_q + TICK_W'(1);
                    if (dec_start) bit_d = '0;
                end
                default: begin
                    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                end
            endcase
        end

        if (dec_bit) begin
            unique case (state_q)
                RX_DATA: begin
                    shift_d[bit_q] = sample;
                    bit_d          = bit_q + BIT_W'(1);
                end
                RX_PARITY: par_d = sample;
                RX_STOP: begin
                    data_d = shift_q;
                    perr_d = ^{shift_q, par_q};
                    ferr_d = ~sample;
                    // A low stop bit means break; wait for the line to go high first.
                    if (sample != STOP_BIT) armed_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            armed_q <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= stop_done;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus break, glitch, back-to-back
// and mid-frame reset sequences.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk per tick

    logic       clk;
    logic       rst;
    logic       baud_clk;
    logic       rx_in;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    rec_t got_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_clk   (baud_clk),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt      = 0;
        baud_clk = 1'b0;
        forever begin
            @(negedge clk);
            baud_clk = (cnt == 3);
            cnt      = (cnt + 1) % 4;
        end
    end

    // Record every rx_valid pulse and check it never lasts more than one clk.
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back('{d: data_out, pe: parity_err, fe: frame_err});
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL rx_valid_width got 2+ cycles expected 1");
            end
        end
        prev_valid <= rx_valid;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic chk_rec(input string name, input int idx, input logic [7:0] d,
                           input logic pe, input logic fe);
        if (got_q.size() > idx) begin
            chk({name, "_data"}, 32'(got_q[idx].d), 32'(d));
            chk({name, "_perr"}, 32'(got_q[idx].pe), 32'(pe));
            chk({name, "_ferr"}, 32'(got_q[idx].fe), 32'(fe));
        end
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] b2b[3];

        vecs[0] = '{d: 8'hA5, par: 1'b0, stop: 1'b1, exp_d: 8'hA5, exp_pe: 1'b0, exp_fe: 1'b0};
        vecs[1] = '{d: 8'h3C, par: 1'b1, stop: 1'b1, exp_d: 8'h3C, exp_pe: 1'b1, exp_fe: 1'b0};
        vecs[2] = '{d: 8'h01, par: 1'b1, stop: 1'b1, exp_d: 8'h01, exp_pe: 1'b0, exp_fe: 1'b0};
        vecs[3] = '{d: 8'hFE, par: 1'b1, stop: 1'b1, exp_d: 8'hFE, exp_pe: 1'b0, exp_fe: 1'b0};
        vecs[4] = '{d: 8'h7E, par: 1'b1, stop: 1'b1, exp_d: 8'h7E, exp_pe: 1'b1, exp_fe: 1'b0};
        vecs[5] = '{d: 8'h12, par: 1'b0, stop: 1'b0, exp_d: 8'h12, exp_pe: 1'b0, exp_fe: 1'b1};

        rst   = 1'b0;
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data", 32'(data_out), 32'h0);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_perr", 32'(parity_err), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        idle_bits(2);

        foreach (vecs[i]) begin
            got_q.delete();
            send_frame(vecs[i].d, vecs[i].par, vecs[i].stop);
            idle_bits(2);
            chk($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'd1);
            chk_rec($sformatf("vec%0d", i), 0, vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
        end

        // Break: low stop bit, line held low; no retrigger until line returns high.
        got_q.delete();
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        chk("break_count", 32'(got_q.size()), 32'd1);
        chk_rec("break", 0, 8'h55, 1'b0, 1'b1);
        chk("break_busy", 32'(busy), 32'h0);
        idle_bits(2);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(2);
        chk("after_break_count", 32'(got_q.size()), 32'd2);
        chk_rec("after_break", 1, 8'h5A, 1'b0, 1'b0);

        // Glitch: 5 ticks low is rejected at the start-bit centre.
        got_q.delete();
        rx_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_busy_high", 32'(busy), 32'h1);
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (32) @(negedge clk);
        chk("glitch_busy_low", 32'(busy), 32'h0);
        idle_bits(3);
        chk("glitch_count", 32'(got_q.size()), 32'd0);

        // Back-to-back frames with no idle between them.
        got_q.delete();
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h81;
        for (int i = 0; i < 3; i++) send_frame(b2b[i], ^b2b[i], 1'b1);
        idle_bits(2);
        chk("b2b_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk_rec($sformatf("b2b%0d", i), i, b2b[i], 1'b0, 1'b0);

        // Reset in the middle of the data bits of 0x96.
        got_q.delete();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx_in = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_data", 32'(data_out), 32'h0);
        chk("midrst_valid", 32'(rx_valid), 32'h0);
        chk("midrst_perr", 32'(parity_err), 32'h0);
        chk("midrst_ferr", 32'(frame_err), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        idle_bits(2);
        send_frame(8'h42, 1'b0, 1'b1);
        idle_bits(2);
        chk("midrst_count", 32'(got_q.size()), 32'd1);
        chk_rec("midrst_frame", 0, 8'h42, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
